// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: widths, write-back control bit positions and
// the register-dump FSM state encoding.
package mips_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int REG_IDX_W       = 5;
  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_LOAD = 2'd1,
    DUMP_SEND = 2'd2,
    DUMP_DONE = 2'd3
  } dump_state_e;

endpackage

// File: rtl/regfile_core.sv
// GPR storage: one write port, two combinational read ports and a dump read port.
// R0 is never written and always reads as zero.
module regfile_core
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter int NUM_REGS   = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        we_i,
  input  logic [$clog2(NUM_REGS)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]       wdata_i,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_a_i,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_b_i,
  input  logic [$clog2(NUM_REGS)-1:0] dump_idx_i,
  output logic [DATA_WIDTH-1:0]       rdata_a_o,
  output logic [DATA_WIDTH-1:0]       rdata_b_o,
  output logic [DATA_WIDTH-1:0]       dump_rdata_o
);

  logic [DATA_WIDTH-1:0] gpr_q [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) gpr_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      gpr_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o    = (raddr_a_i == '0) ? '0 : gpr_q[raddr_a_i];
  assign rdata_b_o    = (raddr_b_i == '0) ? '0 : gpr_q[raddr_b_i];
  assign dump_rdata_o = gpr_q[dump_idx_i];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result mux, GPR file and a ready/valid register-dump FSM.
// Optional macro WB_BYPASS_EN forwards the same-cycle write value to the read ports.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter int NUM_REGS   = 32
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [DATA_WIDTH-1:0]       i_dataread,
  input  logic [DATA_WIDTH-1:0]       i_address,
  input  logic [$clog2(NUM_REGS)-1:0] i_rd_rt,
  input  logic [1:0]                  i_wb,
  input  logic [$clog2(NUM_REGS)-1:0] i_rs_addr,
  input  logic [$clog2(NUM_REGS)-1:0] i_rt_addr,
  output logic [DATA_WIDTH-1:0]       o_rs_data,
  output logic [DATA_WIDTH-1:0]       o_rt_data,
  output logic [DATA_WIDTH-1:0]       o_wb_data,
  input  logic                        i_dump_start,
  output logic [DATA_WIDTH-1:0]       o_dump_data,
  output logic                        o_dump_valid,
  input  logic                        i_dump_ready,
  output logic                        o_dump_busy,
  output logic                        o_dump_done
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic                  write_en;
  logic [DATA_WIDTH-1:0] rs_raw, rt_raw, dump_raw, dump_word;

  dump_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  assign o_wb_data = i_wb[WB_MEMTOREG_BIT] ? i_dataread : i_address;
  assign write_en  = i_wb[WB_REGWRITE_BIT] && (i_rd_rt != '0);

  regfile_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_core (
    .clk_i        (i_clock),
    .rst_ni       (i_reset),
    .we_i         (write_en),
    .waddr_i      (i_rd_rt),
    .wdata_i      (o_wb_data),
    .raddr_a_i    (i_rs_addr),
    .raddr_b_i    (i_rt_addr),
    .dump_idx_i   (idx_q),
    .rdata_a_o    (rs_raw),
    .rdata_b_o    (rt_raw),
    .dump_rdata_o (dump_raw)
  );

`ifdef WB_BYPASS_EN
  assign o_rs_data = (write_en && (i_rs_addr == i_rd_rt)) ? o_wb_data : rs_raw;
  assign o_rt_data = (write_en && (i_rt_addr == i_rd_rt)) ? o_wb_data : rt_raw;
`else
  assign o_rs_data = rs_raw;
  assign o_rt_data = rt_raw;
`endif

  // The dump latches the value the register holds after this edge's write.
  assign dump_word = (write_en && (i_rd_rt == idx_q)) ? o_wb_data : dump_raw;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      DUMP_IDLE: begin
        if (i_dump_start) begin
          state_d = DUMP_LOAD;
          idx_d   = '0;
        end
      end
      DUMP_LOAD: begin
        data_d  = dump_word;
        state_d = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (i_dump_ready) begin
          if (idx_q == IDX_W'(NUM_REGS - 1)) begin
            state_d = DUMP_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = DUMP_LOAD;
          end
        end
      end
      DUMP_DONE: state_d = DUMP_IDLE;
      default:   state_d = DUMP_IDLE;
    endcase
  end

  assign o_dump_data  = data_q;
  assign o_dump_valid = (state_q == DUMP_SEND);
  assign o_dump_busy  = (state_q != DUMP_IDLE);
  assign o_dump_done  = (state_q == DUMP_DONE);

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: write-back mux, R0 handling, read timing and
// the register dump handshake including abort by reset.
module tb_wb_regfile;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [31:0] i_dataread, i_address;
  logic [4:0]  i_rd_rt, i_rs_addr, i_rt_addr;
  logic [1:0]  i_wb;
  logic [31:0] o_rs_data, o_rt_data, o_wb_data, o_dump_data;
  logic        i_dump_start, i_dump_ready;
  logic        o_dump_valid, o_dump_busy, o_dump_done;

  int n_vec = 0;
  int n_err = 0;

  wb_regfile dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_dataread   (i_dataread),
    .i_address    (i_address),
    .i_rd_rt      (i_rd_rt),
    .i_wb         (i_wb),
    .i_rs_addr    (i_rs_addr),
    .i_rt_addr    (i_rt_addr),
    .o_rs_data    (o_rs_data),
    .o_rt_data    (o_rt_data),
    .o_wb_data    (o_wb_data),
    .i_dump_start (i_dump_start),
    .o_dump_data  (o_dump_data),
    .o_dump_valid (o_dump_valid),
    .i_dump_ready (i_dump_ready),
    .o_dump_busy  (o_dump_busy),
    .o_dump_done  (o_dump_done)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] val);
    i_wb = 2'b10; i_rd_rt = rd; i_address = val;
    tick();
    i_wb = 2'b00;
  endtask

  task automatic preload();
    for (int n = 1; n < 32; n++) wr(5'(n), 32'(n) * 32'h11);
  endtask

  // Runs one dump; abort_word >= 0 asserts reset while that word is presented.
  task automatic dump_run(input bit rnd, input int abort_word);
    int words, done_cnt, cyc;
    bit prev_stall, finished, aborted;
    words = 0; done_cnt = 0; cyc = 0;
    prev_stall = 0; finished = 0; aborted = 0;
    i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    check("busy_after_start", 32'(o_dump_busy), 32'd1);
    while (!finished && cyc < 400) begin
      i_dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_dump_start = (cyc == 6) ? 1'b1 : 1'b0;
      if (prev_stall) check("valid_held", 32'(o_dump_valid), 32'd1);
      if (o_dump_valid && abort_word >= 0 && words == abort_word) begin
        #2 i_reset = 1'b0;
        #1;
        check("abort_valid", 32'(o_dump_valid), 32'd0);
        check("abort_busy", 32'(o_dump_busy), 32'd0);
        check("abort_data", o_dump_data, 32'd0);
        check("abort_done", 32'(o_dump_done), 32'd0);
        aborted = 1; finished = 1;
      end else begin
        if (o_dump_valid) check($sformatf("word%0d", words), o_dump_data, 32'(words) * 32'h11);
        if (o_dump_done) done_cnt++;
        prev_stall = o_dump_valid && !i_dump_ready;
        if (o_dump_valid && i_dump_ready) words++;
        tick();
        cyc++;
        if (!o_dump_busy) finished = 1;
      end
    end
    i_dump_start = 1'b0;
    i_dump_ready = 1'b0;
    if (aborted) begin
      check("abort_no_done", 32'(done_cnt), 32'd0);
    end else begin
      check("word_count", 32'(words), 32'd32);
      check("done_pulses", 32'(done_cnt), 32'd1);
      check("busy_end", 32'(o_dump_busy), 32'd0);
      if (!rnd) check("dump_len", 32'(cyc), 32'd65);
    end
  endtask

  initial begin
    i_reset = 1'b0; i_dataread = '0; i_address = '0; i_rd_rt = '0; i_wb = '0;
    i_rs_addr = '0; i_rt_addr = '0; i_dump_start = 1'b0; i_dump_ready = 1'b0;
    tick();
    i_reset = 1'b1;
    tick();

    // 1: reset mid-run clears everything
    wr(5'd3, 32'h3333_3333);
    i_rs_addr = 5'd3;
    #1 check("pre_reset_r3", o_rs_data, 32'h3333_3333);
    #1 i_reset = 1'b0;
    #1;
    check("reset_r3", o_rs_data, 32'd0);
    check("reset_valid", 32'(o_dump_valid), 32'd0);
    check("reset_busy", 32'(o_dump_busy), 32'd0);
    check("reset_done", 32'(o_dump_done), 32'd0);
    check("reset_ddata", o_dump_data, 32'd0);
    tick();
    i_reset = 1'b1;
    tick();
    for (int r = 1; r < 32; r++) begin
      i_rs_addr = 5'(r); i_rt_addr = 5'(31 - r + 1);
      #1;
      check($sformatf("clr_rs%0d", r), o_rs_data, 32'd0);
      check($sformatf("clr_rt%0d", 32 - r), o_rt_data, 32'd0);
    end

    // 2: memtoreg selects load data, otherwise the ALU result
    i_wb = 2'b11; i_rd_rt = 5'd5; i_dataread = 32'hDEAD_BEEF; i_address = 32'h10;
    #1 check("wbmux_load", o_wb_data, 32'hDEAD_BEEF);
    tick();
    i_wb = 2'b00; i_rs_addr = 5'd5;
    #1 check("r5_load", o_rs_data, 32'hDEAD_BEEF);
    i_wb = 2'b10;
    #1 check("wbmux_alu", o_wb_data, 32'h10);
    tick();
    i_wb = 2'b00;
    #1 check("r5_alu", o_rs_data, 32'h10);

    // 3: R0 writes dropped, regwrite=0 ignored
    wr(5'd0, 32'h1234);
    i_rs_addr = 5'd0; i_rt_addr = 5'd0;
    #1 check("r0_rs", o_rs_data, 32'd0);
    check("r0_rt", o_rt_data, 32'd0);
    wr(5'd7, 32'h77);
    i_wb = 2'b00; i_rd_rt = 5'd7; i_address = 32'h9999;
    tick();
    i_rt_addr = 5'd7;
    #1 check("r7_nowrite", o_rt_data, 32'h77);

    // 4: same-cycle write and read of R9
    wr(5'd9, 32'h1);
    i_wb = 2'b11; i_rd_rt = 5'd9; i_dataread = 32'hA5A5_A5A5; i_rs_addr = 5'd9;
    #1;
`ifdef WB_BYPASS_EN
    check("r9_same_cycle", o_rs_data, 32'hA5A5_A5A5);
`else
    check("r9_same_cycle", o_rs_data, 32'h1);
`endif
    tick();
    i_wb = 2'b00;
    #1 check("r9_next_cycle", o_rs_data, 32'hA5A5_A5A5);

    // 5: dump with random back-pressure and a stray start while busy
    preload();
    dump_run(1'b1, -1);

    // 6: abort at word 10, then a clean full-speed dump restarts at R0
    dump_run(1'b0, 10);
    tick();
    check("abort_hold_busy", 32'(o_dump_busy), 32'd0);
    i_reset = 1'b1;
    tick();
    check("post_release_done", 32'(o_dump_done), 32'd0);
    preload();
    dump_run(1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
